// File: rtl/memory_access_sequencer_pkg.sv
// Shared types and constants for the memory access sequencer:
// FSM state encoding, access-type encodings, PC reset value and PC step.
package memory_access_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    STORE,
    DONE
  } state_e;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_FETCH = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;
  localparam int unsigned PC_INCREMENT     = 4;

endpackage

// File: rtl/memory_access_sequencer_enabled_register.sv
// Register with load enable and an asynchronous active-low reset to a
// parameterised value; holds the PC, the instruction register and the MDR.
module enabled_register #(
  parameter int              WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VALUE;
    end else if (load_en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/memory_access_sequencer.sv
// Sequences instruction fetches, loads and stores to a combinational memory,
// one access at a time, with a one-cycle completion pulse and misalignment flag.
module memory_access_sequencer
  import memory_access_sequencer_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PC_RESET   = DATA_WIDTH'(PC_RESET_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Req_Valid_i,
  input  logic [1:0]            Op_i,
  input  logic [DATA_WIDTH-1:0] Data_Address_i,
  input  logic [DATA_WIDTH-1:0] Store_Data_i,
  input  logic                  PC_Load_i,
  input  logic [DATA_WIDTH-1:0] PC_Load_Value_i,
  input  logic [DATA_WIDTH-1:0] Mem_Read_Data_i,
  output logic [DATA_WIDTH-1:0] Mem_Address_o,
  output logic                  Mem_Write_Enable_o,
  output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
  output logic                  Req_Ready_o,
  output logic                  Done_o,
  output logic                  Error_o,
  output logic [DATA_WIDTH-1:0] Instruction_Reg_o,
  output logic [DATA_WIDTH-1:0] Mem_Data_Reg_o,
  output logic [DATA_WIDTH-1:0] PC_o
);

  state_e                state_q;
  state_e                state_next;
  logic                  capture;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;
  logic                  pc_load_en;
  logic [DATA_WIDTH-1:0] pc_d;

  assign misaligned = (Data_Address_i[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Misaligned loads/stores skip the memory state and report through DONE.
  always_comb begin
    state_next = state_q;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Req_Valid_i && (Op_i != OP_NONE)) begin
          capture = 1'b1;
          if (Op_i == OP_FETCH) begin
            state_next = FETCH;
          end else if (misaligned) begin
            state_next = DONE;
          end else if (Op_i == OP_LOAD) begin
            state_next = LOAD;
          end else begin
            state_next = STORE;
          end
        end
      end
      FETCH, LOAD, STORE: state_next = DONE;
      DONE:               state_next = IDLE;
      default:            state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else if (capture) begin
      addr_q <= Data_Address_i;
      data_q <= Store_Data_i;
      err_q  <= (Op_i != OP_FETCH) && misaligned;
    end
  end

  // A redirect only lands in IDLE, so a same-cycle fetch reads the new target.
  assign pc_load_en = ((state_q == IDLE) && PC_Load_i) || (state_q == FETCH);
  assign pc_d       = (state_q == FETCH) ? PC_o + DATA_WIDTH'(PC_INCREMENT)
                                         : PC_Load_Value_i;

  enabled_register #(.WIDTH(DATA_WIDTH), .RESET_VALUE(PC_RESET)) u_pc (
    .clk(clk), .reset(reset), .load_en(pc_load_en), .d(pc_d), .q(PC_o)
  );

  enabled_register #(.WIDTH(DATA_WIDTH), .RESET_VALUE('0)) u_ir (
    .clk(clk), .reset(reset), .load_en(state_q == FETCH),
    .d(Mem_Read_Data_i), .q(Instruction_Reg_o)
  );

  enabled_register #(.WIDTH(DATA_WIDTH), .RESET_VALUE('0)) u_mdr (
    .clk(clk), .reset(reset), .load_en(state_q == LOAD),
    .d(Mem_Read_Data_i), .q(Mem_Data_Reg_o)
  );

  assign Mem_Address_o      = ((state_q == LOAD) || (state_q == STORE)) ? addr_q : PC_o;
  assign Mem_Write_Enable_o = (state_q == STORE);
  assign Mem_Write_Data_o   = data_q;
  assign Req_Ready_o        = (state_q == IDLE);
  assign Done_o             = (state_q == DONE);
  assign Error_o            = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Directed self-checking bench: each accepted request pushes its expected
// outcome to a scoreboard that is popped when Done_o pulses.
module tb_memory_access_sequencer;

  localparam logic [31:0] PC_RST = 32'h0040_0000;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    int          lat;
    int          we_cycles;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        Req_Valid_i;
  logic [1:0]  Op_i;
  logic [31:0] Data_Address_i;
  logic [31:0] Store_Data_i;
  logic        PC_Load_i;
  logic [31:0] PC_Load_Value_i;
  logic [31:0] Mem_Read_Data_i;
  logic [31:0] Mem_Address_o;
  logic        Mem_Write_Enable_o;
  logic [31:0] Mem_Write_Data_o;
  logic        Req_Ready_o;
  logic        Done_o;
  logic        Error_o;
  logic [31:0] Instruction_Reg_o;
  logic [31:0] Mem_Data_Reg_o;
  logic [31:0] PC_o;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [31:0] m_mdr;
  logic [31:0] m_wdata;

  memory_access_sequencer dut (
    .clk(clk), .reset(reset),
    .Req_Valid_i(Req_Valid_i), .Op_i(Op_i),
    .Data_Address_i(Data_Address_i), .Store_Data_i(Store_Data_i),
    .PC_Load_i(PC_Load_i), .PC_Load_Value_i(PC_Load_Value_i),
    .Mem_Read_Data_i(Mem_Read_Data_i),
    .Mem_Address_o(Mem_Address_o), .Mem_Write_Enable_o(Mem_Write_Enable_o),
    .Mem_Write_Data_o(Mem_Write_Data_o), .Req_Ready_o(Req_Ready_o),
    .Done_o(Done_o), .Error_o(Error_o),
    .Instruction_Reg_o(Instruction_Reg_o), .Mem_Data_Reg_o(Mem_Data_Reg_o),
    .PC_o(PC_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one request for one cycle and records what the model predicts.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr,
                               input logic [31:0] data, input logic pc_load,
                               input logic [31:0] pc_val, input logic [31:0] rd);
    exp_t e;
    logic [31:0] pc_eff;
    logic        mis;
    pc_eff = pc_load ? pc_val : m_pc;
    mis    = (op != 2'b01) && (addr[1:0] != 2'b00);
    m_wdata = data;
    e.addr = pc_eff;
    e.err  = mis;
    e.lat  = mis ? 1 : 2;
    e.we_cycles = 0;
    if (op == 2'b01) begin
      m_ir   = rd;
      pc_eff = pc_eff + 32'd4;
    end else if (!mis) begin
      e.addr = addr;
      if (op == 2'b10) m_mdr = rd;
      else e.we_cycles = 1;
    end
    m_pc    = pc_eff;
    e.ir    = m_ir;
    e.mdr   = m_mdr;
    e.pc    = m_pc;
    e.wdata = data;
    sb.push_back(e);
    Req_Valid_i     = 1'b1;
    Op_i            = op;
    Data_Address_i  = addr;
    Store_Data_i    = data;
    PC_Load_i       = pc_load;
    PC_Load_Value_i = pc_val;
    Mem_Read_Data_i = rd;
    stepCycle();
    Req_Valid_i = 1'b0;
    PC_Load_i   = 1'b0;
    Op_i        = 2'b00;
  endtask

  task automatic waitDone(input string tag);
    exp_t e;
    int   lat;
    int   we_seen;
    logic seen;
    e = sb.pop_front();
    lat = 0;
    we_seen = 0;
    seen = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 1) begin
        checkOutput({tag, "_addr"}, Mem_Address_o, e.addr);
        checkOutput({tag, "_busy"}, {31'b0, Req_Ready_o}, 32'd0);
      end
      if (Mem_Write_Enable_o) begin
        we_seen++;
        checkOutput({tag, "_we_addr"}, Mem_Address_o, e.addr);
        checkOutput({tag, "_we_data"}, Mem_Write_Data_o, e.wdata);
      end
      if (Done_o) begin
        lat  = c;
        seen = 1'b1;
        break;
      end
      stepCycle();
    end
    checkOutput({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    checkOutput({tag, "_latency"}, lat, e.lat);
    checkOutput({tag, "_error"}, {31'b0, Error_o}, {31'b0, e.err});
    checkOutput({tag, "_ir"}, Instruction_Reg_o, e.ir);
    checkOutput({tag, "_mdr"}, Mem_Data_Reg_o, e.mdr);
    checkOutput({tag, "_pc"}, PC_o, e.pc);
    checkOutput({tag, "_we_cycles"}, we_seen, e.we_cycles);
    checkOutput({tag, "_wdata_hold"}, Mem_Write_Data_o, e.wdata);
    stepCycle();
    checkOutput({tag, "_done_pulse"}, {31'b0, Done_o}, 32'd0);
    checkOutput({tag, "_ready"}, {31'b0, Req_Ready_o}, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    Req_Valid_i = 1'b0;
    Op_i = 2'b00;
    Data_Address_i = '0;
    Store_Data_i = '0;
    PC_Load_i = 1'b0;
    PC_Load_Value_i = '0;
    Mem_Read_Data_i = '0;
    m_pc = PC_RST;
    m_ir = '0;
    m_mdr = '0;
    m_wdata = '0;
    #22;
    checkOutput("rst_pc", PC_o, PC_RST);
    checkOutput("rst_ir", Instruction_Reg_o, 32'd0);
    checkOutput("rst_mdr", Mem_Data_Reg_o, 32'd0);
    checkOutput("rst_ctrl", {28'b0, Done_o, Error_o, Mem_Write_Enable_o, Req_Ready_o}, 32'd1);
    checkOutput("rst_addr", Mem_Address_o, PC_RST);
    checkOutput("rst_wdata", Mem_Write_Data_o, 32'd0);
    reset = 1'b1;
    stepCycle();

    // Op 00 with valid must be ignored and capture nothing.
    Req_Valid_i = 1'b1;
    Store_Data_i = 32'hAAAA_AAAA;
    stepCycle();
    Req_Valid_i = 1'b0;
    checkOutput("none_ready", {31'b0, Req_Ready_o}, 32'd1);
    checkOutput("none_done", {31'b0, Done_o}, 32'd0);
    checkOutput("none_wdata", Mem_Write_Data_o, m_wdata);
    stepCycle();

    applyStimulus(2'b01, 32'h0, 32'h0, 1'b0, 32'h0, 32'h2008_0005);
    waitDone("fetch");
    applyStimulus(2'b11, 32'h1001_0000, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0);
    waitDone("store");
    applyStimulus(2'b10, 32'h1001_0002, 32'h0, 1'b0, 32'h0, 32'h5555_5555);
    waitDone("load_mis");
    applyStimulus(2'b10, 32'h1001_0004, 32'h0000_0011, 1'b0, 32'h0, 32'h1234_5678);
    waitDone("load");
    applyStimulus(2'b01, 32'h0, 32'h0, 1'b1, 32'h0040_0100, 32'h0BAD_F00D);
    waitDone("redirect");
    applyStimulus(2'b11, 32'h1001_0001, 32'h0F0F_0F0F, 1'b0, 32'h0, 32'h0);
    waitDone("store_mis");

    // Redirect with no request, then a fetch that wraps the PC.
    PC_Load_i = 1'b1;
    PC_Load_Value_i = 32'h1234_0000;
    stepCycle();
    PC_Load_i = 1'b0;
    m_pc = 32'h1234_0000;
    checkOutput("pcload_only", PC_o, m_pc);
    applyStimulus(2'b01, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h1357_9BDF);
    waitDone("wrap");

    applyStimulus(2'b11, 32'h1001_0008, 32'hCAFE_F00D, 1'b0, 32'h0, 32'h0);
    checkOutput("abort_we_pre", {31'b0, Mem_Write_Enable_o}, 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort_we", {31'b0, Mem_Write_Enable_o}, 32'd0);
    checkOutput("abort_idle", {31'b0, Req_Ready_o}, 32'd1);
    checkOutput("abort_pc", PC_o, PC_RST);
    checkOutput("abort_done", {31'b0, Done_o}, 32'd0);
    sb.delete();
    #2 reset = 1'b1;
    stepCycle();
    checkOutput("post_abort_done", {31'b0, Done_o}, 32'd0);
    checkOutput("post_abort_ir", Instruction_Reg_o, 32'd0);

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access_sequencer.md
MEMORY_ACCESS_SEQUENCER -- requirements
Module: memory_access_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of instruction, data, address and PC.
REQ-002 Parameter PC_RESET, default 32'h0040_0000: PC value after reset.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 Req_Valid_i  in  1  control unit requests an access.
REQ-006 Op_i  in  2  access type: 00 none, 01 fetch, 10 load, 11 store.
REQ-007 Data_Address_i  in  DATA_WIDTH  byte address for load/store.
REQ-008 Store_Data_i  in  DATA_WIDTH  store data.
REQ-009 PC_Load_i  in  1  redirect request (branch/jump).
REQ-010 PC_Load_Value_i  in  DATA_WIDTH  redirect target.
REQ-011 Mem_Read_Data_i  in  DATA_WIDTH  combinational read data from memory system.
REQ-012 Mem_Address_o  out  DATA_WIDTH  address to memory system.
REQ-013 Mem_Write_Enable_o  out  1  memory write strobe.
REQ-014 Mem_Write_Data_o  out  DATA_WIDTH  memory write data.
REQ-015 Req_Ready_o  out  1  high only in IDLE.
REQ-016 Done_o  out  1  one-cycle completion pulse.
REQ-017 Error_o  out  1  valid with Done_o; misaligned load/store.
REQ-018 Instruction_Reg_o, Mem_Data_Reg_o, PC_o  out  DATA_WIDTH each  IR, MDR, PC.

Function
REQ-019 FSM states IDLE, FETCH, LOAD, STORE, DONE; Moore outputs.
REQ-020 IDLE: handshake when Req_Valid_i && Op_i!=00; next state FETCH/LOAD/STORE per Op_i; Data_Address_i and Store_Data_i captured into internal registers at that edge.
REQ-021 IDLE with Req_Valid_i && Op_i==00: request ignored, remain IDLE.
REQ-022 Load/store with captured address bits [1:0]!=00: go directly IDLE->DONE, Error_o=1 in DONE, no memory write, MDR unchanged.
REQ-023 FETCH: Mem_Address_o=PC; at edge IR<=Mem_Read_Data_i, PC<=PC+4 (mod 2^DATA_WIDTH); next DONE.
REQ-024 LOAD: Mem_Address_o=captured address; at edge MDR<=Mem_Read_Data_i; next DONE.
REQ-025 STORE: Mem_Address_o=captured address, Mem_Write_Enable_o=1, Mem_Write_Data_o=captured data for exactly one cycle; next DONE.
REQ-026 DONE: Done_o=1 for one cycle; next IDLE unconditionally.
REQ-027 Latency: request accepted at edge N, Done_o high in cycle after edge N+1; back-to-back requests accepted every 3 cycles.
REQ-028 Mem_Write_Enable_o=0 in every state except STORE.
REQ-029 In IDLE, DONE, FETCH: Mem_Address_o=PC; Mem_Write_Data_o holds captured data.
REQ-030 PC_Load_i honoured only in IDLE; PC<=PC_Load_Value_i at that edge; ignored in other states.
REQ-031 PC_Load_i and fetch request in same IDLE cycle: both take effect; FETCH uses redirected PC.
REQ-032 Req_Valid_i outside IDLE ignored; no queuing.

Reset
REQ-033 reset low: state IDLE, PC=PC_RESET, IR=0, MDR=0, captured regs=0, Done_o=0, Error_o=0, Mem_Write_Enable_o=0, independent of clk.
REQ-034 Reset mid-STORE: write strobe deasserts immediately; in-flight access abandoned, no Done_o.

Structure
REQ-035 Shared package holds state enum, Op_i encodings, PC_RESET default, PC increment constant 4.
REQ-036 One sub-module: enabled_register (async active-low reset, load enable, parameterised width and reset value), instantiated for PC, IR, MDR.

Verification
REQ-037 Reset, then fetch with Mem_Read_Data_i=32'h2008_0005 -> IR=32'h2008_0005, PC=32'h0040_0004, Done_o pulse 2 cycles after accept.
REQ-038 Store addr 32'h1001_0000, data 32'hDEAD_BEEF -> exactly one cycle WE=1 with that address/data; Error_o=0.
REQ-039 Load addr 32'h1001_0002 -> no WE, MDR unchanged, Done_o=1 with Error_o=1 one cycle after accept.
REQ-040 PC_Load_i=1, value 32'h0040_0100, plus fetch same cycle -> Mem_Address_o=32'h0040_0100 in FETCH, PC=32'h0040_0104 after.
REQ-041 PC=32'hFFFF_FFFC, fetch -> PC wraps to 0; reset asserted during STORE -> WE drops asynchronously, state IDLE, PC=PC_RESET.
